// File: rtl/cordic_dsp_pkg.sv
// Shared constants, types and arithmetic helpers for the CORDIC/NCO back-end.
// The CORDIC gain constant is used only when IQ_DUMP_GAIN_COMP_EN is defined.
package cordic_dsp_pkg;

  localparam int CORDIC_GAIN_COMP_Q15 = 19898;
  localparam int IQ_OUT_W             = 16;

  typedef struct packed {
    logic [IQ_OUT_W-1:0] I;
    logic [IQ_OUT_W-1:0] Q;
  } iq_sample_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Clamp a wide signed value into a w-bit signed range; flags when it clipped.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                   input int w,
                                                   output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clipped = 1'b1;
    if (x > hi) begin
      sat_clamp = hi;
    end else if (x < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = x;
      clipped   = 1'b0;
    end
  endfunction

endpackage

// File: rtl/iq_out_fifo.sv
// Two-entry valid/ready output buffer. Results arriving while it is full (and
// not draining) are dropped and latch a sticky overflow flag.
module iq_out_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  input  logic         wr_sat,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         sat,
  output logic         overflow
);

  logic [W-1:0] mem_reg  [2];
  logic [W-1:0] mem_next [2];
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         sat_reg;
  logic         overflow_reg;
  logic         pop;
  logic         accept;

  assign pop    = (count_reg != 2'd0) && rd_ready;
  assign accept = wr_valid && ((count_reg != 2'd2) || pop);

  // mem_reg[0] is the head; it is left untouched on the final pop so the
  // outputs keep showing the last value handed over.
  always_comb begin
    mem_next   = mem_reg;
    count_next = count_reg;
    case (count_reg)
      2'd0: begin
        if (accept) begin
          mem_next[0] = wr_data;
          count_next  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && accept) begin
          mem_next[0] = wr_data;
        end else if (pop) begin
          count_next = 2'd0;
        end else if (accept) begin
          mem_next[1] = wr_data;
          count_next  = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          mem_next[0] = mem_reg[1];
          if (accept) mem_next[1] = wr_data;
          else        count_next  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mem_reg[0]   <= '0;
      mem_reg[1]   <= '0;
      count_reg    <= 2'd0;
      sat_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      mem_reg   <= mem_next;
      count_reg <= count_next;
      sat_reg   <= accept && wr_sat;
      if (wr_valid && !accept) overflow_reg <= 1'b1;
    end
  end

  assign rd_valid = (count_reg != 2'd0);
  assign rd_data  = mem_reg[0];
  assign sat      = sat_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/iq_dump_decimator.sv
// Integrate-and-dump I/Q decimator with round-half-up, saturation and a 2-entry
// output buffer. Define IQ_DUMP_GAIN_COMP_EN to add CORDIC gain compensation.
module iq_dump_decimator
  import cordic_dsp_pkg::*;
#(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16,
  parameter int DECIM = 8,
  parameter int SHIFT = 9
) (
  input  logic             CLK_12MHZ,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_I,
  input  logic [IN_W-1:0]  in_Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_I,
  output logic [OUT_W-1:0] out_Q,
  output logic             sat,
  output logic             overflow
);

  localparam int LOG_D = clog2(DECIM);
  localparam int AW    = IN_W + LOG_D;
  localparam logic [LOG_D-1:0]  CNT_LAST = LOG_D'(DECIM - 1);
  localparam logic signed [AW:0] HALF    = (AW + 1)'(1) << (SHIFT - 1);

  logic [LOG_D-1:0]   cnt_reg;
  logic               dump;
  logic [IN_W-1:0]    in_ch      [2];
  logic [OUT_W-1:0]   stage_data [2];
  logic [1:0]         clip;
  logic               res_valid_reg;
  logic               res_sat_reg;
  logic               wr_valid;
  logic               wr_sat;
  logic [2*OUT_W-1:0] wr_data;
  logic [2*OUT_W-1:0] rd_data;

  assign in_ch[0] = in_I;
  assign in_ch[1] = in_Q;
  assign dump     = in_valid && (cnt_reg == CNT_LAST);

  // DECIM is a power of two, so the counter wraps on its own.
  always_ff @(posedge CLK_12MHZ) begin
    if (RESET)         cnt_reg <= '0;
    else if (in_valid) cnt_reg <= cnt_reg + LOG_D'(1);
  end

`ifdef IQ_DUMP_GAIN_COMP_EN
  logic [1:0] gclip;
  logic       gain_valid_reg;
  logic       gain_sat_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [AW-1:0]    acc_reg;
      logic signed [AW-1:0]    sum;
      logic signed [AW:0]      rnd;
      logic signed [OUT_W-1:0] res_next;
      logic signed [OUT_W-1:0] res_reg;
      logic                    clip_loc;

      assign sum = acc_reg + AW'($signed(in_ch[gi]));
      // One guard bit so adding the rounding constant cannot wrap.
      assign rnd = ((AW + 1)'(sum) + HALF) >>> SHIFT;

      always_comb begin
        clip_loc = 1'b0;
        res_next = OUT_W'(sat_clamp(64'(rnd), OUT_W, clip_loc));
      end

      always_ff @(posedge CLK_12MHZ) begin
        if (RESET) begin
          acc_reg <= '0;
          res_reg <= '0;
        end else begin
          if (in_valid) acc_reg <= dump ? '0 : sum;
          if (dump)     res_reg <= res_next;
        end
      end

      assign clip[gi] = clip_loc;

`ifdef IQ_DUMP_GAIN_COMP_EN
      logic signed [OUT_W-1:0] gain_next;
      logic signed [OUT_W-1:0] gain_reg;
      logic                    gclip_loc;

      always_comb begin
        gclip_loc = 1'b0;
        gain_next = OUT_W'(sat_clamp(
            (64'(res_reg) * 64'(CORDIC_GAIN_COMP_Q15) + 64'sd16384) >>> 15,
            OUT_W, gclip_loc));
      end

      always_ff @(posedge CLK_12MHZ) begin
        if (RESET) gain_reg <= '0;
        else       gain_reg <= gain_next;
      end

      assign gclip[gi]      = gclip_loc;
      assign stage_data[gi] = gain_reg;
`else
      assign stage_data[gi] = res_reg;
`endif
    end
  endgenerate

  always_ff @(posedge CLK_12MHZ) begin
    if (RESET) begin
      res_valid_reg <= 1'b0;
      res_sat_reg   <= 1'b0;
    end else begin
      res_valid_reg <= dump;
      res_sat_reg   <= dump && (|clip);
    end
  end

`ifdef IQ_DUMP_GAIN_COMP_EN
  always_ff @(posedge CLK_12MHZ) begin
    if (RESET) begin
      gain_valid_reg <= 1'b0;
      gain_sat_reg   <= 1'b0;
    end else begin
      gain_valid_reg <= res_valid_reg;
      gain_sat_reg   <= res_sat_reg || (res_valid_reg && (|gclip));
    end
  end
  assign wr_valid = gain_valid_reg;
  assign wr_sat   = gain_sat_reg;
`else
  assign wr_valid = res_valid_reg;
  assign wr_sat   = res_sat_reg;
`endif

  assign wr_data = {stage_data[0], stage_data[1]};

  iq_out_fifo #(
    .W(2 * OUT_W)
  ) u_fifo (
    .clk      (CLK_12MHZ),
    .srst     (RESET),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_sat   (wr_sat),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (rd_data),
    .sat      (sat),
    .overflow (overflow)
  );

  assign out_I = rd_data[2*OUT_W-1:OUT_W];
  assign out_Q = rd_data[OUT_W-1:0];

endmodule

// File: tb/tb_iq_dump_decimator.sv
// Self-checking bench for iq_dump_decimator: vector table plus backpressure,
// gapped-input and mid-block reset sequences, with an output scoreboard.
module tb_iq_dump_decimator;
  import cordic_dsp_pkg::*;

  localparam int IN_W  = 22;
  localparam int OUT_W = 16;
`ifdef IQ_DUMP_GAIN_COMP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_I = '0;
  logic [IN_W-1:0]  in_Q = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_I;
  logic [OUT_W-1:0] out_Q;
  logic             sat;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int sat_cnt  = 0;

  iq_sample_t sb[$];
  iq_sample_t mon_e;

  typedef struct {
    int i_val;
    int i_last;
    int q_val;
    int exp_i;
    int exp_q;
    bit exp_sat;
  } vec_t;
  vec_t vecs[7];

  iq_dump_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(8), .SHIFT(9)
  ) dut (
    .CLK_12MHZ (clk),
    .RESET     (rst),
    .in_valid  (in_valid),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_I     (out_I),
    .out_Q     (out_Q),
    .sat       (sat),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected value after the optional gain stage, using an explicit floor.
  function automatic int exp_out(input int x);
`ifdef IQ_DUMP_GAIN_COMP_EN
    longint p;
    longint q;
    p = longint'(x) * 19898 + 16384;
    if (p >= 0) q = p / 32768;
    else        q = -((-p + 32767) / 32768);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input int ei, input int eq);
    iq_sample_t s;
    s.I = 16'(exp_out(ei));
    s.Q = 16'(exp_out(eq));
    sb.push_back(s);
  endtask

  task automatic drive(input int i, input int q);
    @(negedge clk);
    in_valid = 1'b1;
    in_I     = IN_W'(i);
    in_Q     = IN_W'(q);
  endtask

  // Cycles from the last driven sample until out_valid; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
  endtask

  // Output monitor: pops the scoreboard on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got I=%0d Q=%0d, expected none",
                   $signed(out_I), $signed(out_Q));
        end else begin
          mon_e = sb.pop_front();
          check("out_I", $signed(out_I), $signed(mon_e.I));
          check("out_Q", $signed(out_Q), $signed(mon_e.Q));
          $display("pop: I=%0d Q=%0d", $signed(out_I), $signed(out_Q));
        end
        n_out++;
      end
      if (sat) sat_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n0;
    int s0;

    vecs[0] = '{16468,   16468,   0,        257,   0,      1'b0};
    vecs[1] = '{32,      32,      0,        1,     0,      1'b0};
    vecs[2] = '{32,      31,      -32,      0,     0,      1'b0};
    vecs[3] = '{2097151, 2097151, -2097152, 32767, -32768, 1'b1};
    vecs[4] = '{-2097152, -2097152, 0,      -32768, 0,     1'b0};
    vecs[5] = '{100,     100,     -16468,   2,     -257,   1'b0};
    vecs[6] = '{0,       0,       2097151,  0,     32767,  1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sat", sat, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_I", $signed(out_I), 0);
    check("rst_out_Q", $signed(out_Q), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven dumps, consumer always ready
    for (int v = 0; v < 7; v++) begin
      expect_out(vecs[v].exp_i, vecs[v].exp_q);
      for (int j = 0; j < 8; j++)
        drive((j == 7) ? vecs[v].i_last : vecs[v].i_val, vecs[v].q_val);
      wait_out(lat);
      check("latency", lat, LAT);
      check("sat", sat, vecs[v].exp_sat);
      $display("vec %0d: latency=%0d sat=%0d", v, lat, sat);
    end
    idle(3);
    check("no_overflow", overflow, 0);
    check("table_drained", sb.size(), 0);

    // Gapped input
    n0 = n_out;
    expect_out(2, 0);
    for (int j = 0; j < 8; j++) begin
      drive(100, 0);
      @(negedge clk);
      in_valid = 1'b0;
    end
    idle(8);
    check("gapped_outputs", n_out - n0, 1);
    $display("gapped: outputs=%0d", n_out - n0);

    // Backpressure: A and B buffered, saturating C dropped without a sat pulse
    @(negedge clk);
    out_ready = 1'b0;
    s0 = sat_cnt;
    n0 = n_out;
    expect_out(8, 0);
    expect_out(16, 0);
    for (int j = 0; j < 8; j++) drive(512, 0);
    for (int j = 0; j < 8; j++) drive(1024, 0);
    for (int j = 0; j < 8; j++) drive(2097151, 0);
    idle(6);
    check("bp_overflow", overflow, 1);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_hold", $signed(out_I), exp_out(8));
    check("bp_no_sat_on_drop", sat_cnt - s0, 0);
    check("bp_no_pop", n_out - n0, 0);
    @(negedge clk);
    out_ready = 1'b1;
    idle(5);
    check("bp_pops", n_out - n0, 2);
    check("bp_empty", out_valid, 0);
    check("bp_hold_last", $signed(out_I), exp_out(16));
    check("bp_overflow_sticky", overflow, 1);
    $display("backpressure: pops=%0d overflow=%0d", n_out - n0, overflow);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("bp_overflow_cleared", overflow, 0);
    check("rst2_out_I", $signed(out_I), 0);

    // Reset mid-integrate discards the partial sum
    n0 = n_out;
    for (int j = 0; j < 5; j++) drive(1000, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out(2, 0);
    for (int j = 0; j < 8; j++) drive(100, 0);
    wait_out(lat);
    check("midrst_latency", lat, LAT);
    idle(6);
    check("midrst_outputs", n_out - n0, 1);
    $display("mid-reset: outputs=%0d", n_out - n0);

    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_dump_decimator.md
Name: iq_dump_decimator

Overview:
- Downstream consumer of the CORDIC/NCO stage.
- Takes the signed 22-bit I/Q stream (Xout/Yout) and integrates DECIM valid samples per channel.
- Dumps each integrate with round-half-up and saturation to OUT_W, then presents the result through a 2-entry valid/ready output buffer.
- Feeds the sample-rate-reduced I/Q path toward the host/codec interface.

Parameters:
- IN_W, 22, input sample width (signed two's complement).
- OUT_W, 16, output sample width (signed).
- DECIM, 8, samples per dump; power of two, 2..256.
- SHIFT, 9, LSBs dropped from the integrator sum; 1 <= SHIFT <= IN_W+log2(DECIM)-1.

Ports:
- CLK_12MHZ  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  in_I/in_Q hold a valid sample this cycle; no ready, always accepted.
- in_I  in  IN_W  signed I sample (CORDIC Xout).
- in_Q  in  IN_W  signed Q sample (CORDIC Yout).
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- out_I  out  OUT_W  decimated I.
- out_Q  out  OUT_W  decimated Q.
- sat  out  1  pulses one cycle when the written result saturated on either channel.
- overflow  out  1  sticky; a dump was dropped because the buffer was full.

Behaviour:
- Reset:
  - out_valid, sat, overflow = 0; out_I = out_Q = 0.
  - Integrators = 0, sample counter = 0, buffer empty.
  - Reset has priority over every other event; RESET mid-integrate discards partial sums.
- Integrator width AW = IN_W + log2(DECIM), sign-extended inputs; arithmetic cannot overflow.
- Counter: increments only on in_valid cycles and wraps DECIM-1 -> 0. Cycles with in_valid = 0 do not count.
- Dump cycle:
  - Occurs on the in_valid cycle where the counter equals DECIM-1.
  - S = acc + current sample.
  - Integrator reloads 0 the same edge, so there is no lost sample between blocks.
- Rounding: r = (S + 2^(SHIFT-1)) >>> SHIFT, arithmetic (floor) shift.
- Saturation: r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat = 1 for one cycle if either channel clamped.
- Pipeline: dump cycle k -> rounded/saturated result registered at k+1 -> written to buffer at k+2. With an empty buffer, out_valid is high from cycle k+2.
- Output buffer (2 entries, FIFO order):
  - Pop when out_valid & out_ready.
  - Push accepted if count < 2, or count == 2 with a pop the same cycle.
  - Otherwise the result is dropped, overflow is set, and sat is not pulsed for the dropped result.
  - out_I/out_Q show the head and hold stable while out_valid & !out_ready.
  - Simultaneous push and pop at count 1 leaves count 1 with the new head.
- Empty buffer: out_valid = 0; out_I/out_Q hold their last popped value.

Optional Feature:
- Macro: IQ_DUMP_GAIN_COMP_EN.
- Defined:
  - Saturated result is multiplied by 1/An in Q1.15 (19898): y = (x*19898 + 2^14) >>> 15, range-checked to OUT_W.
  - Adds one register stage, so latency is dump k -> buffer write at k+3.
- Undefined: no multiplier and latency k+2.

Decomposition:
- Package cordic_dsp_pkg:
  - CORDIC_GAIN_COMP_Q15 = 19898.
  - clog2 function.
  - typedef iq_sample_t (packed struct {I, Q}, OUT_W each).
  - Sat-clamp function.
- Sub-module iq_out_fifo: 2-entry valid/ready buffer with push/drop and overflow output; width 2*OUT_W.

Test Plan:
- Gain baseline: in_I = 16468, in_Q = 0, in_valid held high for 8 cycles.
  - out_valid rises 2 cycles after the 8th sample (3 with IQ_DUMP_GAIN_COMP_EN).
  - out_I = 257 (156 with gain comp); out_Q = 0; sat = 0.
- Rounding boundary: I = 32 x 8 (S = 256) -> out_I = 1. I sum = 255 (seven 32s plus one 31) -> out_I = 0. I = -32 x 8 -> out_I = 0, since floor(-0.5+0.5) = 0.
- Saturation: I = 2097151 x 8 -> out_I = 32767 with a sat pulse. I = -2097152 x 8 -> out_I = -32768 with no sat.
- Gapped input: 8 valid samples of 100 interleaved with in_valid = 0 gaps -> exactly one output, out_I = 2.
- Backpressure: out_ready = 0 across 3 dumps of distinct values A, B, C.
  - overflow = 1; the buffer holds A then B; C is lost.
  - Raising out_ready pops A, then B; overflow stays 1 until RESET.
- Reset mid-operation: 5 samples of 1000, then RESET for 1 cycle, then 8 samples of 100 -> single output out_I = 2; no output reflects the 1000s.
